// File: rtl/data_mem_port.sv
// data_mem_port
//   Single-port data memory for the load/store path. Features:
//   - byte-lane writes;
//   - a registered read with a one-cycle valid strobe;
//   - out-of-range address detection;
//   - a clear sequencer that zeroes the array after reset or on request.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   clr     - request a full-array clear (level-sampled)
//   req     - access request
//   we      - 1 = write, 0 = read
//   addr    - word address
//   wdata   - write data
//   be      - byte enables for writes, bit i covers wdata[8i+7:8i]
//   ready   - port accepts a request this cycle
//   rvalid  - one-cycle pulse, rdata carries a read result
//   rdata   - read data, zero whenever rvalid is low
//   err     - one-cycle pulse, the accepted request addressed beyond DEPTH-1
module data_mem_port #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9,
    parameter int BE_W   = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ready,
    output logic              rvalid,
    output logic [WIDTH-1:0]  rdata,
    output logic              err
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // One extra bit so the range compare still works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              accept;
    logic              in_range;

    logic              vld_p1;
    logic              err_p1;
    logic [WIDTH-1:0]  rdata_p1;

    // clr has priority over any request issued in the same cycle.
    assign ready    = (state == RUN) && !clr;
    assign accept   = req && ready;
    assign in_range = {1'b0, addr} < DEPTH_X;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // The array carries no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept && we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // ---- stage p1: registered read result and error strobe ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1   <= accept && !we;
            err_p1   <= accept && !in_range;
            rdata_p1 <= (accept && !we && in_range) ? mem[addr] : '0;
        end
    end

    assign rvalid = vld_p1;
    assign err    = err_p1;
    assign rdata  = rdata_p1;

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 400;
    localparam int ADDR_W = 9;
    localparam int BE_W   = WIDTH / 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr   = 1'b0;
    logic              req   = 1'b0;
    logic              we    = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [WIDTH-1:0]  wdata = '0;
    logic [BE_W-1:0]   be    = '0;
    logic              ready;
    logic              rvalid;
    logic [WIDTH-1:0]  rdata;
    logic              err;

    always #5 clk = ~clk;

    data_mem_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .ready (ready),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word contents plus the number of sweep cycles still owed.
    int model [DEPTH];
    int clear_left;
    int exp_rvalid;
    int exp_err;
    int exp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_ready(input bit c);
        return (clear_left == 0 && !c) ? 1 : 0;
    endfunction

    task automatic model_reset();
        clear_left = DEPTH;
        exp_rvalid = 0;
        exp_err    = 0;
        exp_rdata  = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
    endtask

    // One clock cycle: drive inputs, check ready, predict the edge, check outputs.
    task automatic step(input bit c, input bit r, input bit w, input int a, input int d, input int b);
        int acc;
        clr   = c;
        req   = r;
        we    = w;
        addr  = a[ADDR_W-1:0];
        wdata = d[WIDTH-1:0];
        be    = b[BE_W-1:0];
        #1;
        check("ready", 32'(ready), 32'(exp_ready(c)));
        acc        = (r && exp_ready(c) == 1) ? 1 : 0;
        exp_rvalid = 0;
        exp_err    = 0;
        exp_rdata  = 0;
        if (clear_left > 0) begin
            clear_left = c ? DEPTH : clear_left - 1;
        end else if (c) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model[i] = 0;
        end else if (acc == 1) begin
            if (a < DEPTH) begin
                if (w) begin
                    for (int i = 0; i < BE_W; i++)
                        if (b[i]) model[a] = (model[a] & ~(32'hFF << (8*i))) | (d & (32'hFF << (8*i)));
                end else begin
                    exp_rvalid = 1;
                    exp_rdata  = model[a];
                end
            end else begin
                exp_err    = 1;
                exp_rvalid = w ? 0 : 1;
            end
        end
        @(posedge clk);
        #1;
        check("rvalid", 32'(rvalid), 32'(exp_rvalid));
        check("err",    32'(err),    32'(exp_err));
        check("rdata",  32'(rdata),  32'(exp_rdata));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d, input int b);
        step(1'b0, 1'b1, 1'b1, a, d, b);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, 1'b0, a, 0, 0);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_rdata",  32'(rdata),  32'd0);
        check("rst_ready",  32'(ready),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  32'(ready),  32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata",  32'(rdata),  32'd0);
        check("reset_err",    32'(err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep after reset: ready low for DEPTH cycles, then high.
        idle(DEPTH);
        idle(1);
        rd(0);
        rd(200);
        rd(399);

        // Full-word writes then back-to-back reads.
        wr(0, 'hAAAA, 3);
        wr(1, 'hBBBB, 3);
        wr(2, 'hCCCC, 3);
        wr(399, 'hDDDD, 3);
        rd(0);
        rd(1);
        rd(2);
        rd(399);

        // Byte lanes.
        wr(5, 'h1234, 3);
        wr(5, 'hFF00, 2);
        rd(5);
        wr(5, 'h0000, 0);
        rd(5);

        // Out-of-range accesses.
        wr(400, 'h5555, 3);
        rd(511);
        rd(0);

        // Read-after-write in consecutive cycles.
        wr(7, 'h0F0F, 3);
        rd(7);

        // clr beats a simultaneous write.
        wr(0, 'hAAAA, 3);
        step(1'b1, 1'b1, 1'b1, 3, 'h7777, 3);
        idle(DEPTH);
        rd(0);
        rd(3);

        // clr during the sweep restarts it.
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(50);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(DEPTH);
        rd(10);

        // Reset at sweep count 100.
        reset_pulse();
        idle(100);
        reset_pulse();
        idle(DEPTH);
        wr(9, 'h4321, 3);
        rd(9);

        // Reset in the cycle after an accepted read.
        reset_pulse();
        idle(DEPTH);
        wr(9, 'h4321, 3);
        rd(9);
        reset_pulse();
        idle(DEPTH + 1);

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 3000; n++) begin
            bit c, r, w;
            int a;
            c = ($urandom_range(0, 499) == 0);
            r = ($urandom_range(0, 9) < 7);
            w = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       a = $urandom_range(DEPTH, (1 << ADDR_W) - 1);
                1, 2:    a = $urandom_range(DEPTH - 4, DEPTH - 1);
                3, 4, 5: a = $urandom_range(0, 7);
                default: a = $urandom_range(0, DEPTH - 1);
            endcase
            step(c, r, w, a, int'($urandom_range(0, 'hFFFF)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Parametrised single-port data memory for the processor's load/store path, replacing the fixed 400×16 array. It adds byte-lane writes, a registered read with a valid strobe, out-of-range address detection, and a hardware clear sequencer. The sequencer zeroes the array after reset or on request. It sits between the load/store unit and the register-file write-back mux.

## Interface
- `WIDTH`, 16: data word width in bits; must be a multiple of 8.
- `DEPTH`, 400: number of words; need not be a power of two.
- `ADDR_W`, 9: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `BE_W`, WIDTH/8: derived byte-enable width; not to be overridden.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  request a full-array clear; level-sampled.
- `req`  in  1  access request.
- `we`  in  1  1 = write, 0 = read; valid with `req`.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  WIDTH  write data.
- `be`  in  BE_W  byte enables for writes; bit i covers `wdata[8i+7:8i]`; ignored on reads.
- `ready`  out  1  port accepts a request this cycle.
- `rvalid`  out  1  one-cycle pulse: `rdata` carries read result.
- `rdata`  out  WIDTH  read data; 0 whenever `rvalid` = 0.
- `err`  out  1  one-cycle pulse: the accepted request had `addr` ≥ DEPTH.

## Operation
- FSM states:
  - CLEAR: a clear counter walks 0..DEPTH-1 and writes 0 to one word per cycle.
  - RUN: normal access.
- FSM transitions:
  - `rst_n` low → CLEAR, counter = 0.
  - CLEAR with counter = DEPTH-1 → RUN on that edge, after writing the last word.
  - RUN with `clr` = 1 → CLEAR, counter = 0.
  - CLEAR with `clr` = 1 → counter restarts at 0.
- `ready` = (state == RUN) && !`clr`; purely combinational from state and `clr`.
- Acceptance: a request is accepted on an edge where `req` && `ready`. Requests while `ready` = 0 are dropped silently: no write, no `rvalid`, no `err`.
- Accepted write, `addr` < DEPTH: each lane with `be[i]` = 1 is updated on the accepting edge; other lanes are unchanged. `be` = 0 is a legal no-op write.
- Accepted read, `addr` < DEPTH: the word is captured into `rdata` on the accepting edge.
- Out-of-range address (`addr` ≥ DEPTH, e.g. 400..511 at defaults):
  - no array access;
  - a read returns `rdata` = 0 with `rvalid` = 1;
  - `err` = 1 for both reads and writes.
- Back-to-back accepted requests are legal every cycle.
- Read-after-write to the same address in the next cycle returns the newly written data.
- Memory contents are undefined between reset assertion and completion of the CLEAR sweep.

## Timing
- Reset values: `ready` 0, `rvalid` 0, `rdata` 0, `err` 0, state CLEAR, counter 0.
- Clear duration: exactly DEPTH cycles. `ready` rises in the cycle after the edge that writes word DEPTH-1, i.e. after DEPTH rising edges following `rst_n` deassertion (400 at defaults).
- Read latency: 1 cycle. `rvalid`/`rdata`/`err` are valid in the cycle after the accepting edge and return to 0 on the following edge unless another read is accepted.
- Write `err` appears in the cycle after the accepting edge, alone; `rvalid` stays 0.
- `clr` asserted in RUN in the same cycle as `req`: `clr` wins; the request is dropped and the CLEAR sweep begins on that edge.
- Reset mid-CLEAR or mid-read: all outputs go to 0 immediately (asynchronously); any pending `rvalid` is lost; the sweep restarts.

## Test plan
- Reset, wait: `ready` = 0 for 400 cycles after `rst_n` rises, then 1; reading addr 0, 200 and 399 returns 0x0000 with `rvalid` pulse.
- Write 0xAAAA @0, 0xBBBB @1, 0xCCCC @2, 0xDDDD @399 with `be` = 2'b11, then read each back-to-back → 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD on consecutive `rvalid` cycles, `err` = 0.
- Write 0x1234 @5 with `be` = 2'b11, then 0xFF00 with `be` = 2'b10 → read returns 0xFF34; a write with `be` = 2'b00 leaves 0xFF34.
- Write 0x5555 @400, then read @511 → `err` pulses each time; read gives `rdata` 0 with `rvalid` 1; word @0 is unchanged.
- After writing 0xAAAA @0, assert `clr` together with a write of 0x7777 @3 → `ready` drops; after 400 cycles, reads @0 and @3 return 0x0000.
- Pulse `rst_n` low at clear count 100 and in the cycle after an accepted read → outputs 0 immediately; `rvalid` never appears; `ready` returns 400 cycles after release.
